fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 18 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch unit and its buffer.
package fetch_pkg;

    localparam int XLEN = 32;

    // Every instruction is one 32-bit word.
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // One buffered fetch: where it came from and what came back.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular buffer with push/pop/flush.
// Push and pop in the same cycle leave the level unchanged.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;

    assign level     = count;
    assign full      = (count == LW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush behaves like reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since count guards reads.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, one-deep in-flight tracking
// and credit-based flow control into a small fetch buffer.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR =
        DATA_WIDTH'(DEFAULT_RESET_VECTOR),
    localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o,
    output logic [DATA_WIDTH-1:0] instr_pc_plus4_o,
    output logic [LW-1:0]         level_o
);

    localparam int EW = 2 * DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(INSTR_BYTES);

    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] inflight_pc;
    logic                  inflight;

    logic [LW:0]           occupancy;
    logic                  credit_ok;
    logic                  req;
    logic                  push;
    logic                  pop;

    logic [LW-1:0]         fifo_level;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [EW-1:0]         push_entry;
    logic [EW-1:0]         head_entry;

    logic [1:0]            redirect_pc_unused;

    // Redirect targets are forced to word alignment, so the low bits drop.
    assign redirect_pc_unused = redirect_pc_i[1:0];

    // Entries already buffered plus the one still coming back from memory
    // must never exceed the buffer size, so a response always has a slot.
    assign occupancy = {1'b0, fifo_level} + (LW + 1)'(inflight);
    assign credit_ok = occupancy < (LW + 1)'(FIFO_DEPTH);

    assign req  = credit_ok & ~redirect_i & ~rst_i;
    assign push = inflight & ~redirect_i & ~rst_i;
    assign pop  = instr_valid_o & instr_ready_i;

    assign push_entry = {inflight_pc, imem_rdata_i};

    assign imem_req_o  = req;
    assign imem_addr_o = rst_i ? RESET_VECTOR : fetch_pc;

    assign instr_valid_o    = ~fifo_empty & ~redirect_i & ~rst_i;
    assign instr_pc_o       = head_entry[EW-1:DATA_WIDTH];
    assign instr_o          = head_entry[DATA_WIDTH-1:0];
    assign instr_pc_plus4_o = instr_pc_o + STEP;
    assign level_o          = rst_i ? '0 : fifo_level;

    // Fetch PC and in-flight tracking; reset beats redirect beats fetch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc    <= RESET_VECTOR;
            inflight    <= 1'b0;
            inflight_pc <= RESET_VECTOR;
        end else if (redirect_i) begin
            fetch_pc    <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
            inflight    <= 1'b0;
        end else begin
            inflight <= req;
            if (req) begin
                fetch_pc    <= fetch_pc + STEP;
                inflight_pc <= fetch_pc;
            end
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (redirect_i),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A push into a full buffer without a matching pop means the
    // credit accounting above is broken.
    a_no_overflow : assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(push && fifo_full && !pop)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency memory model.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [31:0] instr_pc_plus4_o;
    logic [2:0]  level_o;

    int checks   = 0;
    int failures = 0;

    fetch_unit dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_rdata_i     (imem_rdata_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_pc_plus4_o (instr_pc_plus4_o),
        .level_o          (level_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory answers exactly one cycle after a request.
    always @(posedge clk_i) begin
        if (imem_req_o) imem_rdata_i <= instr_of(imem_addr_o);
        else            imem_rdata_i <= 32'hBAD0_BAD0;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b1;

        // Reset state
        @(negedge clk_i); #1;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_addr", imem_addr_o, 32'h0);

        // Streaming with ready held high
        @(negedge clk_i); rst_i = 1'b0; #1;
        chk("s0_req", 32'(imem_req_o), 32'd1);
        chk("s0_addr", imem_addr_o, 32'h0);
        chk("s0_valid", 32'(instr_valid_o), 32'd0);
        @(negedge clk_i); #1;
        chk("s1_addr", imem_addr_o, 32'h4);
        chk("s1_valid", 32'(instr_valid_o), 32'd0);
        @(negedge clk_i); #1;
        chk("s2_valid", 32'(instr_valid_o), 32'd1);
        chk("s2_pc", instr_pc_o, 32'h0);
        chk("s2_instr", instr_o, 32'hDEAD_0000);
        chk("s2_pc4", instr_pc_plus4_o, 32'h4);
        chk("s2_level", 32'(level_o), 32'd1);
        chk("s2_addr", imem_addr_o, 32'h8);
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk_i); #1;
            chk("s_valid", 32'(instr_valid_o), 32'd1);
            chk("s_pc", instr_pc_o, 32'(4 * (k - 2)));
            chk("s_instr", instr_o, instr_of(32'(4 * (k - 2))));
            chk("s_addr", imem_addr_o, 32'(4 * k));
        end

        // Back-pressure: buffer fills, requests stop, then drains in order
        @(negedge clk_i); rst_i = 1'b1; instr_ready_i = 1'b0; #1;
        chk("bp_rst_valid", 32'(instr_valid_o), 32'd0);
        chk("bp_rst_level", 32'(level_o), 32'd0);
        @(negedge clk_i); rst_i = 1'b0; #1;
        chk("bp0_addr", imem_addr_o, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i); #1;
            chk("bp_req", 32'(imem_req_o), 32'd1);
            chk("bp_addr", imem_addr_o, 32'(4 * c));
        end
        @(negedge clk_i); #1;
        chk("bp4_req", 32'(imem_req_o), 32'd0);
        chk("bp4_level", 32'(level_o), 32'd3);
        @(negedge clk_i); #1;
        chk("bp5_req", 32'(imem_req_o), 32'd0);
        chk("bp5_level", 32'(level_o), 32'd4);
        chk("bp5_pc", instr_pc_o, 32'h0);
        @(negedge clk_i); #1;
        chk("bp6_req", 32'(imem_req_o), 32'd0);
        chk("bp6_level", 32'(level_o), 32'd4);
        chk("bp6_addr", imem_addr_o, 32'h10);
        @(negedge clk_i); instr_ready_i = 1'b1; #1;
        chk("dr7_pc", instr_pc_o, 32'h0);
        chk("dr7_level", 32'(level_o), 32'd4);
        chk("dr7_req", 32'(imem_req_o), 32'd0);
        @(negedge clk_i); #1;
        chk("dr8_pc", instr_pc_o, 32'h4);
        chk("dr8_level", 32'(level_o), 32'd3);
        chk("dr8_req", 32'(imem_req_o), 32'd1);
        chk("dr8_addr", imem_addr_o, 32'h10);
        for (int c = 9; c <= 11; c++) begin
            @(negedge clk_i); #1;
            chk("dr_valid", 32'(instr_valid_o), 32'd1);
            chk("dr_pc", instr_pc_o, 32'(4 * (c - 7)));
        end

        // Redirect while level=3 with a request in flight
        @(negedge clk_i); rst_i = 1'b1; instr_ready_i = 1'b0; #1;
        @(negedge clk_i); rst_i = 1'b0; #1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i); #1;
        end
        @(negedge clk_i); redirect_i = 1'b1; redirect_pc_i = 32'h103; #1;
        chk("rd4_level", 32'(level_o), 32'd3);
        chk("rd4_req", 32'(imem_req_o), 32'd0);
        chk("rd4_valid", 32'(instr_valid_o), 32'd0);
        @(negedge clk_i); redirect_i = 1'b0; instr_ready_i = 1'b1; #1;
        chk("rd5_level", 32'(level_o), 32'd0);
        chk("rd5_valid", 32'(instr_valid_o), 32'd0);
        chk("rd5_req", 32'(imem_req_o), 32'd1);
        chk("rd5_addr", imem_addr_o, 32'h100);
        @(negedge clk_i); #1;
        chk("rd6_valid", 32'(instr_valid_o), 32'd0);
        chk("rd6_level", 32'(level_o), 32'd0);
        chk("rd6_addr", imem_addr_o, 32'h104);
        @(negedge clk_i); #1;
        chk("rd7_valid", 32'(instr_valid_o), 32'd1);
        chk("rd7_pc", instr_pc_o, 32'h100);
        chk("rd7_instr", instr_o, instr_of(32'h100));

        // Redirect coincident with a valid handshake
        @(negedge clk_i); redirect_i = 1'b1; redirect_pc_i = 32'h200; #1;
        chk("rv8_valid", 32'(instr_valid_o), 32'd0);
        chk("rv8_req", 32'(imem_req_o), 32'd0);
        @(negedge clk_i); redirect_i = 1'b0; #1;
        chk("rv9_valid", 32'(instr_valid_o), 32'd0);
        chk("rv9_level", 32'(level_o), 32'd0);
        chk("rv9_addr", imem_addr_o, 32'h200);
        @(negedge clk_i); #1;
        chk("rv10_valid", 32'(instr_valid_o), 32'd0);
        @(negedge clk_i); #1;
        chk("rv11_valid", 32'(instr_valid_o), 32'd1);
        chk("rv11_pc", instr_pc_o, 32'h200);

        // Back-to-back redirects: the last one wins
        @(negedge clk_i); redirect_i = 1'b1; redirect_pc_i = 32'h300; #1;
        chk("rr0_req", 32'(imem_req_o), 32'd0);
        @(negedge clk_i); redirect_pc_i = 32'h402; #1;
        chk("rr1_req", 32'(imem_req_o), 32'd0);
        @(negedge clk_i); redirect_i = 1'b0; #1;
        chk("rr2_req", 32'(imem_req_o), 32'd1);
        chk("rr2_addr", imem_addr_o, 32'h400);
        @(negedge clk_i); #1;
        chk("rr3_valid", 32'(instr_valid_o), 32'd0);
        @(negedge clk_i); #1;
        chk("rr4_pc", instr_pc_o, 32'h400);

        // PC wrap at the top of the address space
        @(negedge clk_i); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF; #1;
        @(negedge clk_i); redirect_i = 1'b0; #1;
        chk("wr_addr0", imem_addr_o, 32'hFFFF_FFFC);
        @(negedge clk_i); #1;
        chk("wr_addr1", imem_addr_o, 32'h0);
        @(negedge clk_i); #1;
        chk("wr_pc0", instr_pc_o, 32'hFFFF_FFFC);
        chk("wr_pc4_0", instr_pc_plus4_o, 32'h0);
        @(negedge clk_i); #1;
        chk("wr_pc1", instr_pc_o, 32'h0);
        chk("wr_pc4_1", instr_pc_plus4_o, 32'h4);

        // Reset mid-stream drops everything and restarts at the vector
        @(negedge clk_i); rst_i = 1'b1; #1;
        chk("mr_req", 32'(imem_req_o), 32'd0);
        chk("mr_valid", 32'(instr_valid_o), 32'd0);
        chk("mr_level", 32'(level_o), 32'd0);
        chk("mr_addr", imem_addr_o, 32'h0);
        @(negedge clk_i); rst_i = 1'b0; #1;
        chk("mr0_req", 32'(imem_req_o), 32'd1);
        chk("mr0_addr", imem_addr_o, 32'h0);
        chk("mr0_level", 32'(level_o), 32'd0);
        chk("mr0_valid", 32'(instr_valid_o), 32'd0);
        @(negedge clk_i); #1;
        chk("mr1_level", 32'(level_o), 32'd0);
        chk("mr1_valid", 32'(instr_valid_o), 32'd0);
        @(negedge clk_i); #1;
        chk("mr2_valid", 32'(instr_valid_o), 32'd1);
        chk("mr2_pc", instr_pc_o, 32'h0);
        chk("mr2_instr", instr_o, 32'hDEAD_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
